// File: rtl/hub75_frame_buffer.sv
// hub75_frame_buffer: double-buffered, quantising RGB pixel store feeding the HUB75 BRAM driver.
// Optional macro HUB75_FRAME_BUFFER_GAMMA_EN selects gamma-2.2 ROM quantisation with one extra write stage.
module hub75_frame_buffer #(
    parameter int NUM_PIXELS      = 128,
    parameter int NUM_BLOCK_ROWS  = 16,
    parameter int POWER_MOD       = 16,
    localparam int LOG_POWER_MOD  = $clog2(POWER_MOD),
    localparam int ADDRESS_SIZE   = $clog2(NUM_BLOCK_ROWS * NUM_PIXELS),
    localparam int PIXEL_SIZE     = 3 * LOG_POWER_MOD
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [23:0]             in_data,
    input  logic                    in_sof,
    input  logic                    frame_sync_in,
    input  logic                    row_0_data_valid,
    input  logic [ADDRESS_SIZE-1:0] row_0_pixel_address,
    output logic [PIXEL_SIZE-1:0]   row_0_pixel_data,
    input  logic                    row_1_data_valid,
    input  logic [ADDRESS_SIZE-1:0] row_1_pixel_address,
    output logic [PIXEL_SIZE-1:0]   row_1_pixel_data,
    output logic                    front_page_out,
    output logic [7:0]              frames_dropped_out
);

    localparam int X_W       = $clog2(NUM_PIXELS);
    localparam int Y_W       = $clog2(2 * NUM_BLOCK_ROWS);
    localparam int MEM_DEPTH = 2 ** (ADDRESS_SIZE + 1);
    localparam int L         = LOG_POWER_MOD;

    typedef enum logic {
        FILL,
        WAIT_SWAP
    } state_t;

    state_t            r_state;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_frontPage;
    logic              r_shownValid;
    logic [7:0]        r_framesDropped;

    logic                    w_accept;
    logic                    w_atOrigin;
    logic [X_W-1:0]          w_wx;
    logic [Y_W-1:0]          w_wy;
    logic                    w_bank;
    logic [Y_W-1:0]          w_row;
    logic [ADDRESS_SIZE-1:0] w_addr;

    logic                    w_wrEn;
    logic                    w_wrBank;
    logic                    w_wrPage;
    logic [ADDRESS_SIZE-1:0] w_wrAddr;
    logic [PIXEL_SIZE-1:0]   w_wrData;
    logic                    w_wrPending;

    assign in_ready   = rst_n_in && (r_state == FILL);
    assign w_accept   = in_valid && in_ready;
    assign w_atOrigin = (r_x == '0) && (r_y == '0);

    // An SOF pixel always lands at the origin, whatever the counters say.
    assign w_wx   = in_sof ? '0 : r_x;
    assign w_wy   = in_sof ? '0 : r_y;
    assign w_bank = (w_wy >= Y_W'(NUM_BLOCK_ROWS));
    assign w_row  = w_bank ? (w_wy - Y_W'(NUM_BLOCK_ROWS)) : w_wy;
    assign w_addr = ADDRESS_SIZE'(int'(w_row) * NUM_PIXELS + int'(w_wx));

`ifdef HUB75_FRAME_BUFFER_GAMMA_EN
    logic                    r_pipeValid;
    logic                    r_pipeBank;
    logic                    r_pipePage;
    logic [ADDRESS_SIZE-1:0] r_pipeAddr;
    logic [23:0]             r_pipeData;
    logic [L-1:0]            w_gammaRom [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_gammaRom
        localparam int GV = $rtoi((((real'(gi) / 255.0) ** 2.2) * real'(POWER_MOD - 1)) + 0.5);
        assign w_gammaRom[gi] = L'(GV);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_pipeValid <= 1'b0;
        end else begin
            r_pipeValid <= w_accept;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_pipeData <= in_data;
            r_pipeBank <= w_bank;
            r_pipeAddr <= w_addr;
            r_pipePage <= ~r_frontPage;
        end
    end

    assign w_wrEn      = r_pipeValid;
    assign w_wrBank    = r_pipeBank;
    assign w_wrPage    = r_pipePage;
    assign w_wrAddr    = r_pipeAddr;
    assign w_wrData    = {w_gammaRom[r_pipeData[7:0]], w_gammaRom[r_pipeData[15:8]],
                          w_gammaRom[r_pipeData[23:16]]};
    assign w_wrPending = r_pipeValid;
`else
    logic [3*(8-L)-1:0] w_unusedBits;

    assign w_wrEn       = w_accept;
    assign w_wrBank     = w_bank;
    assign w_wrPage     = ~r_frontPage;
    assign w_wrAddr     = w_addr;
    assign w_wrData     = {in_data[7 -: L], in_data[15 -: L], in_data[23 -: L]};
    assign w_wrPending  = 1'b0;
    assign w_unusedBits = {in_data[16 +: 8-L], in_data[8 +: 8-L], in_data[0 +: 8-L]};
`endif

    // Fill/swap controller: the back page fills, then waits for the driver's frame boundary.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state         <= FILL;
            r_x             <= '0;
            r_y             <= '0;
            r_frontPage     <= 1'b0;
            r_shownValid    <= 1'b0;
            r_framesDropped <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (in_sof && !w_atOrigin && (r_framesDropped != 8'hFF)) begin
                            r_framesDropped <= r_framesDropped + 8'd1;
                        end
                        if (w_wx == X_W'(NUM_PIXELS - 1)) begin
                            r_x <= '0;
                            if (w_wy == Y_W'(2 * NUM_BLOCK_ROWS - 1)) begin
                                r_y     <= '0;
                                r_state <= WAIT_SWAP;
                            end else begin
                                r_y <= w_wy + Y_W'(1);
                            end
                        end else begin
                            r_x <= w_wx + X_W'(1);
                            r_y <= w_wy;
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (frame_sync_in && !w_wrPending) begin
                        r_frontPage  <= ~r_frontPage;
                        r_shownValid <= 1'b1;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_state      <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    logic [PIXEL_SIZE-1:0] r_bank0 [MEM_DEPTH];
    logic [PIXEL_SIZE-1:0] r_bank1 [MEM_DEPTH];
    logic [PIXEL_SIZE-1:0] r_row0Raw;
    logic [PIXEL_SIZE-1:0] r_row1Raw;
    logic                  r_row0Blank;
    logic                  r_row1Blank;

    // Page bit is the address MSB so each bank maps onto one simple dual-port RAM.
    always_ff @(posedge clk_in) begin
        if (w_wrEn && !w_wrBank) begin
            r_bank0[{w_wrPage, w_wrAddr}] <= w_wrData;
        end
        if (w_wrEn && w_wrBank) begin
            r_bank1[{w_wrPage, w_wrAddr}] <= w_wrData;
        end
    end

    always_ff @(posedge clk_in) begin
        if (row_0_data_valid) begin
            r_row0Raw <= r_bank0[{r_frontPage, row_0_pixel_address}];
        end
        if (row_1_data_valid) begin
            r_row1Raw <= r_bank1[{r_frontPage, row_1_pixel_address}];
        end
    end

    // Blanking travels with the read so the RAM output register itself needs no reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_row0Blank <= 1'b1;
            r_row1Blank <= 1'b1;
        end else begin
            if (row_0_data_valid) begin
                r_row0Blank <= ~r_shownValid;
            end
            if (row_1_data_valid) begin
                r_row1Blank <= ~r_shownValid;
            end
        end
    end

    assign row_0_pixel_data   = r_row0Blank ? '0 : r_row0Raw;
    assign row_1_pixel_data   = r_row1Blank ? '0 : r_row1Raw;
    assign front_page_out     = r_frontPage;
    assign frames_dropped_out = r_framesDropped;

endmodule

// File: doc/hub75_frame_buffer.md
Name: hub75_frame_buffer

Overview:
- Double-buffered pixel store that sits directly upstream of the HUB75 BRAM driver.
- Accepts a raster RGB888 pixel stream over valid/ready and quantises each channel to LOG_POWER_MOD bits.
- Writes the top half of the panel into bank 0 and the bottom half into bank 1 of the back page.
- Serves the driver's two row read ports from the front page; pages swap only on a frame-sync pulse, so the panel never shows a torn frame.

Parameters:
- NUM_PIXELS, 128, pixels per panel row.
- NUM_BLOCK_ROWS, 16, rows per half-panel; panel height is 2*NUM_BLOCK_ROWS.
- POWER_MOD, 16, PWM levels per channel; LOG_POWER_MOD = clog2(POWER_MOD).
- Derived: ADDRESS_SIZE = clog2(NUM_BLOCK_ROWS*NUM_PIXELS), PIXEL_SIZE = 3*LOG_POWER_MOD.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_n_in  input  1  synchronous, active-low reset.
- in_valid  input  1  stream pixel valid.
- in_ready  output  1  stream pixel ready.
- in_data  input  24  {r[23:16], g[15:8], b[7:0]}.
- in_sof  input  1  first pixel of frame; qualified by in_valid.
- frame_sync_in  input  1  one-cycle pulse at the driver's power-frame boundary.
- row_0_data_valid  input  1  top-half read enable.
- row_0_pixel_address  input  ADDRESS_SIZE  top-half read address.
- row_0_pixel_data  output  PIXEL_SIZE  top-half read data.
- row_1_data_valid  input  1  bottom-half read enable.
- row_1_pixel_address  input  ADDRESS_SIZE  bottom-half read address.
- row_1_pixel_data  output  PIXEL_SIZE  bottom-half read data.
- front_page_out  output  1  page currently being displayed.
- frames_dropped_out  output  8  saturating count of aborted partial frames.

Behaviour:
- Reset (rst_n_in low at posedge):
  - state=FILL, x=0, y=0, front_page=0 (back page=1), shown_valid=0, frames_dropped=0.
  - Row data outputs = 0. in_ready = 0 while rst_n_in is low.
  - Memory contents are not cleared.
- Pixel format: bits [LOG_POWER_MOD-1:0]=r, next field=g, top field=b.
- Quantisation: each channel = its top LOG_POWER_MOD bits (c >> (8-LOG_POWER_MOD)).
- Write addressing:
  - Accept = in_valid && in_ready.
  - Bank select: y < NUM_BLOCK_ROWS writes bank 0, else bank 1.
  - Address = (y mod NUM_BLOCK_ROWS)*NUM_PIXELS + x. Writes go to the back page only.
- Counters:
  - x wraps at NUM_PIXELS-1 and increments y.
  - Accepting the pixel with x=NUM_PIXELS-1, y=2*NUM_BLOCK_ROWS-1 moves state to WAIT_SWAP.
- State machine:
  - FILL: in_ready=1.
  - WAIT_SWAP: in_ready=0.
  - WAIT_SWAP -> FILL on frame_sync_in. That same cycle: front_page toggles, shown_valid=1, x=y=0.
  - frame_sync_in in FILL has no effect.
  - frame_sync_in in the same cycle as the last-pixel accept has no effect; the swap waits for the next pulse.
- SOF resync:
  - An accepted in_sof pixel is always written at x=0, y=0.
  - If (x,y) != (0,0) at that accept, the partial frame is abandoned and frames_dropped increments, saturating at 255.
  - An accepted non-SOF pixel at (0,0) is written normally; no SOF is required.
- Read side:
  - Latency is 1 cycle: data for the address presented with valid high at cycle N is visible after edge N+1.
  - When valid is low, data holds its last value.
  - Reads use front_page sampled in the same cycle as the address. A read coincident with the swap cycle uses the old page.
  - While shown_valid=0, read data is forced to 0 (blank panel until the first complete frame).
- Storage: 2 pages × 2 banks × NUM_BLOCK_ROWS*NUM_PIXELS × PIXEL_SIZE. Implemented as block RAM: one write port and one read port per bank, with page as the MSB of the address.
- Out-of-range addresses (≥ NUM_BLOCK_ROWS*NUM_PIXELS) return undefined data; the bench does not check them.

Optional Feature:
- Macro: HUB75_FRAME_BUFFER_GAMMA_EN.
- Defined: quantisation uses a 256-entry ROM per channel: out = round(((c/255)^2.2)*(POWER_MOD-1)). Input is registered one extra cycle before the write. in_ready and acceptance timing are unchanged; write latency grows by 1, and the swap is held until the final pipelined write lands.
- Undefined: plain truncation as above; no ROM is built.

Test Plan:
- Reset, then read addr 5 on both ports with no frame loaded -> row_0/row_1 data = 0; in_ready=1; front_page_out=0.
- Stream one full frame (4096 pixels) with pixel (x=3,y=0) = 0xF08010 and (x=3,y=16) = 0x00FF00; pulse frame_sync_in -> front_page_out=1 next cycle. Row_0 addr 3 reads r=15,g=8,b=1 (0x18F). Row_1 addr 3 reads g=15 only (0x0F0).
- Finish a second frame, then hold in_valid=1 -> in_ready stays 0 until frame_sync_in. Pulse coincident with the last accept -> no swap; the next pulse swaps.
- Assert in_sof at pixel index 200 of a frame -> frames_dropped_out=1; that pixel is stored at address 0 of bank 0; the frame completes 4096 accepts later.
- Drive row_0_data_valid with address 130 at cycle N, then drop valid -> data for addr 130 appears at N+1 and holds.
- With HUB75_FRAME_BUFFER_GAMMA_EN: channel values 0/128/255 -> 0/3/15. Without the macro: 0/8/15.
